fifo_hexdump_tx: RTL and testbench

Downstream drain for the first-word-fallthrough byte FIFO. It pops bytes from the FIFO read side and transmits them on an 8N1 UART line, either as an ASCII hex dump or as raw bytes. It sits between the SPI capture FIFO and the board's serial TX pin, so logged flash traffic can be read on a host terminal. The block is self-paced: it pops a byte only when it can immediately start sending it.

---
 rtl/fifo_hexdump_tx.sv | 159 +++++++++++++++
 tb/tb_fifo_hexdump_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_hexdump_tx.sv
// Drains a first-word-fallthrough byte FIFO onto an 8N1 UART line, either as an
// ASCII hex dump (two digits plus space, CR/LF at line end) or as raw bytes.
module fifo_hexdump_tx #(
  parameter int unsigned DIVISOR        = 16,
  parameter bit          HEX            = 1'b1,
  parameter int unsigned BYTES_PER_LINE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_available,
  input  logic [7:0] read_data,
  output logic       read_strobe,
  output logic       serial,
  output logic       busy
);

  localparam int unsigned DivW  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int unsigned LineW = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
  localparam logic [DivW-1:0]  DivLast  = DivW'(DIVISOR - 1);
  localparam logic [LineW-1:0] LineLast = LineW'(BYTES_PER_LINE - 1);

  typedef enum logic [2:0] {StIdle, StHi, StLo, StSep, StCr, StLf, StRaw} state_e;

  state_e           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [LineW-1:0] line_q, line_d;

  logic             ser_active_q, ser_active_d;
  logic [3:0]       bit_q, bit_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [7:0]       shift_q, shift_d;
  logic             serial_q, serial_d;

  logic             ser_done;
  logic             ser_start;
  logic [7:0]       ser_char;
  logic             pop;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // Last cycle of the stop bit; the next character may be loaded in this cycle.
  assign ser_done = ser_active_q && (div_q == DivLast) && (bit_q == 4'd9);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:             if (pop) state_d = HEX ? StHi : StRaw;
      StHi:               if (ser_done) state_d = StLo;
      StLo:               if (ser_done) state_d = (line_q == LineLast) ? StCr : StSep;
      StCr:               if (ser_done) state_d = StLf;
      StSep, StLf, StRaw: if (ser_done) state_d = StIdle;
      default:            state_d = StIdle;
    endcase
  end

  // The first character of a record is built straight from read_data so the
  // start bit can go out on the cycle after the pop.
  always_comb begin
    pop       = 1'b0;
    ser_start = 1'b0;
    ser_char  = 8'h00;
    unique case (state_q)
      StIdle: begin
        pop       = reset && data_available && !ser_active_q;
        ser_start = pop;
        ser_char  = HEX ? hex_ascii(read_data[7:4]) : read_data;
      end
      StHi: begin
        ser_start = ser_done;
        ser_char  = hex_ascii(hold_q[3:0]);
      end
      StLo: begin
        ser_start = ser_done;
        ser_char  = (line_q == LineLast) ? 8'h0D : 8'h20;
      end
      StCr: begin
        ser_start = ser_done;
        ser_char  = 8'h0A;
      end
      default: ;
    endcase
  end

  assign read_strobe = pop;
  assign busy        = (state_q != StIdle) || ser_active_q;
  assign serial      = serial_q;

  always_comb begin
    hold_d       = pop ? read_data : hold_q;
    line_d       = line_q;
    ser_active_d = ser_active_q;
    bit_d        = bit_q;
    div_d        = div_q;
    shift_d      = shift_q;
    serial_d     = serial_q;

    if (ser_done && state_q == StLo && line_q != LineLast) begin
      line_d = line_q + 1'b1;
    end else if (ser_done && state_q == StLf) begin
      line_d = '0;
    end

    if (ser_active_q) begin
      if (div_q == DivLast) begin
        div_d = '0;
        if (bit_q == 4'd9) begin
          ser_active_d = 1'b0;
          serial_d     = 1'b1;
        end else begin
          // Shifting in ones leaves the stop bit in place after the 8 data bits.
          bit_d    = bit_q + 4'd1;
          serial_d = shift_q[0];
          shift_d  = {1'b1, shift_q[7:1]};
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    if (ser_start) begin
      ser_active_d = 1'b1;
      bit_d        = 4'd0;
      div_d        = '0;
      shift_d      = ser_char;
      serial_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q       <= 8'h00;
      line_q       <= '0;
      ser_active_q <= 1'b0;
      bit_q        <= 4'd0;
      div_q        <= '0;
      shift_q      <= 8'h00;
      serial_q     <= 1'b1;
    end else begin
      hold_q       <= hold_d;
      line_q       <= line_d;
      ser_active_q <= ser_active_d;
      bit_q        <= bit_d;
      div_q        <= div_d;
      shift_q      <= shift_d;
      serial_q     <= serial_d;
    end
  end

endmodule

// File: tb/tb_fifo_hexdump_tx.sv
// Directed bench for fifo_hexdump_tx: a hex-mode and a raw-mode instance, a UART
// receiver on the selected serial line, and tables of bytes with expected text.
module tb_fifo_hexdump_tx;

  localparam int unsigned Div = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       da = 1'b0;
  logic [7:0] rd = 8'h00;
  logic       use_raw = 1'b0;

  logic da_hex, strobe_hex, serial_hex, busy_hex;
  logic da_raw, strobe_raw, serial_raw, busy_raw;
  logic mon_strobe, mon_ser, mon_busy;

  assign da_hex     = da & ~use_raw;
  assign da_raw     = da & use_raw;
  assign mon_strobe = use_raw ? strobe_raw : strobe_hex;
  assign mon_ser    = use_raw ? serial_raw : serial_hex;
  assign mon_busy   = use_raw ? busy_raw : busy_hex;

  fifo_hexdump_tx #(.DIVISOR(Div), .HEX(1'b1), .BYTES_PER_LINE(16)) u_hex (
    .clk            (clk),
    .reset          (reset),
    .data_available (da_hex),
    .read_data      (rd),
    .read_strobe    (strobe_hex),
    .serial         (serial_hex),
    .busy           (busy_hex)
  );

  fifo_hexdump_tx #(.DIVISOR(Div), .HEX(1'b0), .BYTES_PER_LINE(16)) u_raw (
    .clk            (clk),
    .reset          (reset),
    .data_available (da_raw),
    .read_data      (rd),
    .read_strobe    (strobe_raw),
    .serial         (serial_raw),
    .busy           (busy_raw)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // UART receiver: bit k is sampled k*Div cycles after the first start-bit cycle.
  logic [7:0] rx_q[$];
  int         rx_t[$];

  initial begin : rx_mon
    logic [7:0] b;
    int         st;
    forever begin
      @(negedge clk);
      if (reset && mon_ser === 1'b0) begin
        st = cyc;
        for (int k = 0; k < 8; k++) begin
          repeat (Div) @(negedge clk);
          b[k] = mon_ser;
        end
        repeat (Div) @(negedge clk);
        check("stop_bit", 32'(mon_ser), 32'd1);
        rx_q.push_back(b);
        rx_t.push_back(st);
      end
    end
  end

  typedef struct {
    logic [7:0] din;
    int         nch;
  } vec_t;

  vec_t       vec[$];
  logic [7:0] exp_q[$];

  task automatic load_exp(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
  endtask

  // Presents vec[] as a FWFT FIFO, then checks text, character timing and pop spacing.
  task automatic run_stream(input string tag);
    int pop_t[$];
    int idx = 0;
    int budget = 0;
    int n_exp = 0;
    int j = 0;
    int dur;
    bit done = 1'b0;
    foreach (vec[i]) n_exp += vec[i].nch;
    while (!done && budget < 6000) begin
      @(posedge clk);
      #1;
      da = (idx < vec.size());
      rd = (idx < vec.size()) ? vec[idx].din : 8'h00;
      @(negedge clk);
      budget++;
      if (mon_strobe) begin
        pop_t.push_back(cyc);
        idx++;
      end
      if (idx == vec.size() && !mon_strobe) begin
        dur = vec[idx-1].nch * 10 * Div;
        if (cyc == pop_t[idx-1] + dur) check({tag, " busy_in_stop"}, 32'(mon_busy), 32'd1);
        if (cyc == pop_t[idx-1] + dur + 1) begin
          check({tag, " busy_after"}, 32'(mon_busy), 32'd0);
          check({tag, " serial_after"}, 32'(mon_ser), 32'd1);
          done = 1'b1;
        end
      end
    end
    da = 1'b0;
    if (!done) check({tag, " timeout"}, 32'd0, 32'd1);
    check({tag, " pop_count"}, pop_t.size(), vec.size());
    check({tag, " char_count"}, rx_q.size(), n_exp);
    foreach (vec[i]) begin
      for (int k = 0; k < vec[i].nch; k++) begin
        if (j < rx_q.size() && i < pop_t.size()) begin
          check($sformatf("%s char%0d", tag, j), rx_q[j], exp_q[j]);
          check($sformatf("%s start%0d", tag, j), rx_t[j], pop_t[i] + 1 + k * 10 * Div);
        end
        j++;
      end
    end
    for (int i = 1; i < pop_t.size(); i++) begin
      check($sformatf("%s pop_gap%0d", tag, i), pop_t[i] - pop_t[i-1],
            vec[i-1].nch * 10 * Div + 1);
    end
  endtask

  initial begin
    bit any_s, any_l, any_b;
    int t0;

    // Reset values
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst serial_hex", 32'(serial_hex), 32'd1);
    check("rst serial_raw", 32'(serial_raw), 32'd1);
    check("rst strobe_hex", 32'(strobe_hex), 32'd0);
    check("rst strobe_raw", 32'(strobe_raw), 32'd0);
    check("rst busy_hex", 32'(busy_hex), 32'd0);
    check("rst busy_raw", 32'(busy_raw), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Empty FIFO for 1000 cycles
    any_s = 1'b0; any_l = 1'b0; any_b = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (strobe_hex || strobe_raw) any_s = 1'b1;
      if (!(serial_hex && serial_raw)) any_l = 1'b1;
      if (busy_hex || busy_raw) any_b = 1'b1;
    end
    check("idle strobe_seen", 32'(any_s), 32'd0);
    check("idle serial_low", 32'(any_l), 32'd0);
    check("idle busy_seen", 32'(any_b), 32'd0);

    // Hex: 0x00..0x0F fill one line, then 0x3A opens the next one
    clear_rx();
    vec.delete();
    for (int i = 0; i < 16; i++) vec.push_back('{din: 8'(i), nch: (i == 15) ? 4 : 3});
    vec.push_back('{din: 8'h3A, nch: 3});
    load_exp({"00 01 02 03 04 05 06 07 08 09 0A 0B 0C 0D 0E 0F", "\015\012", "3A "});
    run_stream("hex1");

    // Reset during data bit 4 of the 'A' digit of 0x3A
    clear_rx();
    @(posedge clk);
    #1;
    da = 1'b1;
    rd = 8'h3A;
    t0 = -1;
    for (int n = 0; n < 50 && t0 < 0; n++) begin
      @(negedge clk);
      if (strobe_hex) t0 = cyc;
    end
    check("rstmid pop_seen", 32'(t0 >= 0), 32'd1);
    @(posedge clk);
    #1 da = 1'b0;
    repeat (62) @(negedge clk);
    check("rstmid cycle", cyc, t0 + 62);
    check("rstmid serial_bit4", 32'(serial_hex), 32'd0);
    check("rstmid busy_before", 32'(busy_hex), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("rstmid serial_next", 32'(serial_hex), 32'd1);
    check("rstmid busy_next", 32'(busy_hex), 32'd0);
    da = 1'b1;
    rd = 8'h55;
    any_s = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (strobe_hex) any_s = 1'b1;
    end
    check("rstmid no_strobe_in_reset", 32'(any_s), 32'd0);
    da = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (60) @(negedge clk);
    check("rstmid busy_released", 32'(busy_hex), 32'd0);
    check("rstmid serial_released", 32'(serial_hex), 32'd1);

    // After reset the line count is 0 again: CR/LF follows the 16th byte
    clear_rx();
    vec.delete();
    for (int i = 0; i < 16; i++) vec.push_back('{din: 8'(8'h10 + i), nch: (i == 15) ? 4 : 3});
    load_exp({"10 11 12 13 14 15 16 17 18 19 1A 1B 1C 1D 1E 1F", "\015\012"});
    run_stream("hex2");

    // Raw mode
    use_raw = 1'b1;
    repeat (5) @(negedge clk);
    clear_rx();
    vec.delete();
    vec.push_back('{din: 8'hA5, nch: 1});
    vec.push_back('{din: 8'h00, nch: 1});
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00);
    run_stream("raw");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
